// File: rtl/axis_block_rr_arbiter.sv
// Two-input AXI-Stream arbiter that switches sources only on BDIM/SDIM-beat block boundaries.
// Define BLOCK_COUNTER_EN to add per-source completed-block counters (blk_count0/blk_count1).
module axis_block_rr_arbiter #(
    parameter int ELEM_WIDTH = 8,
    parameter int SDIM       = 4,
    parameter int BDIM       = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [1:0]                 cfg_mask,
    input  logic [ELEM_WIDTH*SDIM-1:0] s_axis_input0_tdata,
    input  logic                       s_axis_input0_tvalid,
    output logic                       s_axis_input0_tready,
    input  logic [ELEM_WIDTH*SDIM-1:0] s_axis_input1_tdata,
    input  logic                       s_axis_input1_tvalid,
    output logic                       s_axis_input1_tready,
    output logic [ELEM_WIDTH*SDIM-1:0] m_axis_output0_tdata,
    output logic                       m_axis_output0_tvalid,
    input  logic                       m_axis_output0_tready,
    output logic                       m_axis_output0_tlast,
    output logic                       m_axis_output0_tuser,
`ifdef BLOCK_COUNTER_EN
    output logic [CNT_WIDTH-1:0]       blk_count0,
    output logic [CNT_WIDTH-1:0]       blk_count1,
`endif
    output logic                       busy
);

    localparam int DW  = ELEM_WIDTH * SDIM;
    localparam int BPB = BDIM / SDIM;
    localparam int BCW = (BPB > 1) ? $clog2(BPB) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BPB - 1);

    generate
        if ((BDIM % SDIM) != 0 || BPB < 1) begin : g_bad_block_dims
            $error("BDIM must be a nonzero multiple of SDIM");
        end
        if (CNT_WIDTH < 1) begin : g_bad_cnt_width
            $error("CNT_WIDTH must be at least 1");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t           state;
    logic             grant;
    logic             last_grant;
    logic [BCW-1:0]   beat_cnt;

    logic             ld_ok;
    logic             grant_valid;
    logic [DW-1:0]    grant_data;
    logic             accept;
    logic             last_beat;
    logic [1:0]       req;
    logic             winner;

    assign ld_ok       = !m_axis_output0_tvalid || m_axis_output0_tready;
    assign grant_valid = grant ? s_axis_input1_tvalid : s_axis_input0_tvalid;
    assign grant_data  = grant ? s_axis_input1_tdata  : s_axis_input0_tdata;
    assign accept      = (state == XFER) && grant_valid && ld_ok;
    assign last_beat   = (beat_cnt == LAST_BEAT);

    assign s_axis_input0_tready = (state == XFER) && !grant && ld_ok;
    assign s_axis_input1_tready = (state == XFER) &&  grant && ld_ok;
    assign busy                 = (state == XFER);

    // A lone requester wins outright; a tie goes to whoever did not own the previous block.
    assign req    = {s_axis_input1_tvalid & cfg_mask[1], s_axis_input0_tvalid & cfg_mask[0]};
    assign winner = (req == 2'b11) ? !last_grant : req[1];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state                 <= IDLE;
            grant                 <= 1'b0;
            last_grant            <= 1'b1;
            beat_cnt              <= '0;
            m_axis_output0_tdata  <= '0;
            m_axis_output0_tvalid <= 1'b0;
            m_axis_output0_tlast  <= 1'b0;
            m_axis_output0_tuser  <= 1'b0;
        end else begin
            if (ld_ok) begin
                m_axis_output0_tvalid <= accept;
                if (accept) begin
                    m_axis_output0_tdata <= grant_data;
                    m_axis_output0_tlast <= last_beat;
                    m_axis_output0_tuser <= grant;
                end
            end

            case (state)
                IDLE: begin
                    if (|req) begin
                        grant    <= winner;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    // The grant is held through source stalls and output backpressure until the block ends.
                    if (accept) begin
                        if (last_beat) begin
                            last_grant <= grant;
                            beat_cnt   <= '0;
                            state      <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BCW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BLOCK_COUNTER_EN
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            blk_count0 <= '0;
            blk_count1 <= '0;
        end else if (accept && last_beat) begin
            if (grant) begin
                blk_count1 <= blk_count1 + CNT_WIDTH'(1);
            end else begin
                blk_count0 <= blk_count0 + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_block_rr_arbiter.sv
// Scoreboard bench for axis_block_rr_arbiter: per-source data queues plus an expected block-source order.
module tb_axis_block_rr_arbiter;

    localparam int EW   = 8;
    localparam int SDIM = 4;
    localparam int BDIM = 16;
    localparam int CW   = 32;
    localparam int BPB  = BDIM / SDIM;
    localparam int DW   = EW * SDIM;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic [1:0]    cfg_mask;
    logic [DW-1:0] s0_tdata, s1_tdata;
    logic          s0_tvalid, s1_tvalid;
    logic          s0_tready, s1_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tready, m_tlast, m_tuser;
    logic          busy;
`ifdef BLOCK_COUNTER_EN
    logic [CW-1:0] blk_count0, blk_count1;
`endif

    always #5 ap_clk = ~ap_clk;

    axis_block_rr_arbiter #(
        .ELEM_WIDTH(EW), .SDIM(SDIM), .BDIM(BDIM), .CNT_WIDTH(CW)
    ) dut (
        .ap_clk                (ap_clk),
        .ap_rst                (ap_rst),
        .cfg_mask              (cfg_mask),
        .s_axis_input0_tdata   (s0_tdata),
        .s_axis_input0_tvalid  (s0_tvalid),
        .s_axis_input0_tready  (s0_tready),
        .s_axis_input1_tdata   (s1_tdata),
        .s_axis_input1_tvalid  (s1_tvalid),
        .s_axis_input1_tready  (s1_tready),
        .m_axis_output0_tdata  (m_tdata),
        .m_axis_output0_tvalid (m_tvalid),
        .m_axis_output0_tready (m_tready),
        .m_axis_output0_tlast  (m_tlast),
        .m_axis_output0_tuser  (m_tuser),
`ifdef BLOCK_COUNTER_EN
        .blk_count0            (blk_count0),
        .blk_count1            (blk_count1),
`endif
        .busy                  (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] snd0[$];
    logic [DW-1:0] snd1[$];
    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];
    int            exp_src[$];

    int cyc = 0;
    int gap_pct0 = 0, gap_pct1 = 0, ready_pct = 100;
    int hold1 = 0, stall_after1 = 0, stall_len = 0;
    int acc0 = 0, acc1 = 0;
    int first_in = -1, first_out = -1, last_out = -1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One block of BPB random beats for a source, mirrored into that source's expected queue.
    task automatic applyStimulus(input int src);
        logic [DW-1:0] d;
        for (int b = 0; b < BPB; b++) begin
            d = DW'($urandom);
            if (src == 0) begin snd0.push_back(d); exp0.push_back(d); end
            else          begin snd1.push_back(d); exp1.push_back(d); end
        end
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        snd0.delete(); snd1.delete(); exp0.delete(); exp1.delete(); exp_src.delete();
        acc0 = 0; acc1 = 0;
        @(negedge ap_clk);
        checkOutput("reset_ctrl", {m_tvalid, m_tlast, m_tuser, busy, s0_tready, s1_tready}, 0);
        checkOutput("reset_tdata", m_tdata, 0);
`ifdef BLOCK_COUNTER_EN
        checkOutput("reset_cnt0", blk_count0, 0);
        checkOutput("reset_cnt1", blk_count1, 0);
`endif
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int done = 0;
        for (int k = 0; k < 3000 && done == 0; k++) begin
            @(negedge ap_clk);
            if (snd0.size() == 0 && snd1.size() == 0 && exp0.size() == 0 && exp1.size() == 0 &&
                !busy && !m_tvalid)
                done = 1;
        end
        checkOutput({name, "_drain"}, done, 1);
        checkOutput({name, "_blocks_left"}, exp_src.size(), 0);
        exp_src.delete();
    endtask

    task automatic wait_busy(input string name);
        int seen = 0;
        for (int k = 0; k < 50 && seen == 0; k++) begin
            @(negedge ap_clk);
            if (busy) seen = 1;
        end
        checkOutput(name, seen, 1);
    endtask

    // Driver: holds tvalid until accepted, inserts random gaps and a programmable stall on input 1.
    initial begin : driver
        logic took0, took1;
        took0 = 1'b0; took1 = 1'b0;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        s0_tdata = '0; s1_tdata = '0;
        m_tready = 1'b1;
        forever begin
            @(posedge ap_clk);
            cyc++;
            #1;
            if (ap_rst) begin
                s0_tvalid = 1'b0; s1_tvalid = 1'b0;
                took0 = 1'b0; took1 = 1'b0; hold1 = 0;
                m_tready = 1'b1;
                continue;
            end
            if (!s0_tvalid || took0) begin
                took0 = 1'b0;
                if (snd0.size() > 0 && int'($urandom_range(99)) >= gap_pct0) begin
                    s0_tvalid = 1'b1; s0_tdata = snd0[0];
                end else s0_tvalid = 1'b0;
            end
            if (!s1_tvalid || took1) begin
                took1 = 1'b0;
                if (hold1 > 0) begin
                    hold1--; s1_tvalid = 1'b0;
                end else if (snd1.size() > 0 && int'($urandom_range(99)) >= gap_pct1) begin
                    s1_tvalid = 1'b1; s1_tdata = snd1[0];
                end else s1_tvalid = 1'b0;
            end
            m_tready = int'($urandom_range(99)) < ready_pct;
            if (first_in < 0 && (s0_tvalid || s1_tvalid)) first_in = cyc;
            #1;
            if (s0_tvalid && s0_tready) begin
                took0 = 1'b1; void'(snd0.pop_front()); acc0++;
            end
            if (s1_tvalid && s1_tready) begin
                took1 = 1'b1; void'(snd1.pop_front()); acc1++;
                if (stall_after1 != 0 && acc1 == stall_after1) hold1 = stall_len;
            end
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks AXI-S hold rules.
    initial begin : monitor
        int            out_pos;
        logic          cur_src, prev_stall, p_last, p_user;
        logic [DW-1:0] p_data;
        int            e;
        out_pos = 0; cur_src = 1'b0; prev_stall = 1'b0;
        p_last = 1'b0; p_user = 1'b0; p_data = '0;
        forever begin
            @(posedge ap_clk);
            #3;
            if (ap_rst) begin
                out_pos = 0; prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                checkOutput("hold_valid", m_tvalid, 1);
                checkOutput("hold_beat", {m_tdata, m_tlast, m_tuser}, {p_data, p_last, p_user});
            end
            if (m_tvalid && !m_tready)
                checkOutput("stall_tready", {s0_tready, s1_tready}, 0);
            if (m_tvalid && m_tready) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (out_pos == 0) begin
                    cur_src = m_tuser;
                    if (exp_src.size() > 0) begin
                        e = exp_src.pop_front();
                        checkOutput("block_src", m_tuser, e);
                    end
                end else begin
                    checkOutput("interleave", m_tuser, cur_src);
                end
                if ((m_tuser ? exp1.size() : exp0.size()) == 0) begin
                    n_cmp++; n_bad++;
                    $display("[TB] FAIL unexpected_beat: got 0x%0h from source %0d, expected none", m_tdata, m_tuser);
                end else if (m_tuser) checkOutput("data1", m_tdata, exp1.pop_front());
                else                  checkOutput("data0", m_tdata, exp0.pop_front());
                checkOutput("tlast", m_tlast, out_pos == BPB - 1);
                out_pos = (out_pos == BPB - 1) ? 0 : out_pos + 1;
            end
            prev_stall = m_tvalid && !m_tready;
            p_data = m_tdata; p_last = m_tlast; p_user = m_tuser;
        end
    end

    initial begin : main
        logic [DW-1:0] d;
        int            ok;
        ap_rst = 1'b1;
        cfg_mask = 2'b11;
        @(negedge ap_clk);
        do_reset();

        $display("[TB] both inputs continuous, alternating blocks, output backpressure");
        ready_pct = 60;
        for (int b = 0; b < 4; b++) begin
            applyStimulus(0); applyStimulus(1);
            exp_src.push_back(0); exp_src.push_back(1);
        end
        drain("alternate");

        $display("[TB] single source 0x01..0x08, latency and bubble");
        ready_pct = 100;
        first_in = -1; first_out = -1; last_out = -1;
        for (int i = 1; i <= 8; i++) begin
            d = DW'(i);
            snd0.push_back(d); exp0.push_back(d);
        end
        exp_src.push_back(0); exp_src.push_back(0);
        drain("single");
        checkOutput("latency", first_out - first_in, 2);
        checkOutput("span_one_bubble", last_out - first_out, 8);

        $display("[TB] granted input 1 stalls mid-block while input 0 waits");
        acc1 = 0; stall_after1 = 2; stall_len = 5;
        applyStimulus(1);
        exp_src.push_back(1); exp_src.push_back(0);
        wait_busy("stall_grant");
        applyStimulus(0);
        drain("stall");
        stall_after1 = 0;

        $display("[TB] cfg_mask change during a block");
        cfg_mask = 2'b01;
        applyStimulus(0); applyStimulus(0); applyStimulus(1);
        exp_src.push_back(0); exp_src.push_back(1); exp_src.push_back(0);
        wait_busy("mask_grant");
        @(negedge ap_clk);
        @(negedge ap_clk);
        cfg_mask = 2'b10;
        ok = 0;
        for (int k = 0; k < 100 && ok == 0; k++) begin
            @(negedge ap_clk);
            if (exp1.size() == 0) ok = 1;
        end
        checkOutput("mask_src1_done", ok, 1);
        repeat (5) @(negedge ap_clk);
        checkOutput("mask_src0_blocked", exp0.size(), BPB);
        cfg_mask = 2'b11;
        drain("mask");

        $display("[TB] randomized gaps and backpressure");
        gap_pct0 = 30; gap_pct1 = 30; ready_pct = 70;
        for (int b = 0; b < 5; b++) begin
            applyStimulus(0); applyStimulus(1);
        end
        drain("random");
        gap_pct0 = 0; gap_pct1 = 0; ready_pct = 100;

        $display("[TB] reset mid-block, then round robin restarts at input 0");
        applyStimulus(0);
        exp_src.push_back(0);
        drain("pre_reset");
        acc0 = 0;
        applyStimulus(0);
        ok = 0;
        for (int k = 0; k < 50 && ok == 0; k++) begin
            @(negedge ap_clk);
            if (acc0 >= 2) ok = 1;
        end
        checkOutput("reset_setup", ok, 1);
        do_reset();
        for (int b = 0; b < 3; b++) begin
            applyStimulus(0); applyStimulus(1);
            exp_src.push_back(0); exp_src.push_back(1);
        end
        drain("post_reset");
`ifdef BLOCK_COUNTER_EN
        checkOutput("blk_count0", blk_count0, 3);
        checkOutput("blk_count1", blk_count1, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_block_rr_arbiter.md
Name: axis_block_rr_arbiter

Overview:
- Shares one AXI-Stream output between two input streams, switching only on block boundaries.
- A block is BDIM elements delivered in SDIM-element beats, so one block is BDIM/SDIM beats.
- Sits upstream of a kernel whose input interface carries BDIM/SDIM tiling. Guarantees the kernel never sees blocks from different sources interleaved.
- Generates tlast at block end and tags each beat with its source id.

Parameters:
- ELEM_WIDTH, 8, bits per element.
- SDIM, 4, elements per beat; tdata width = ELEM_WIDTH*SDIM.
- BDIM, 16, elements per block; must be a nonzero multiple of SDIM. BPB = BDIM/SDIM beats per block, which must be ≥1.
- CNT_WIDTH, 32, width of optional block counters.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- cfg_mask  in  2  per-input enable, bit i enables input i; sampled only in IDLE.
- s_axis_input0_tdata  in  ELEM_WIDTH*SDIM  input 0 beat.
- s_axis_input0_tvalid  in  1  input 0 valid.
- s_axis_input0_tready  out  1  input 0 ready.
- s_axis_input1_tdata  in  ELEM_WIDTH*SDIM  input 1 beat.
- s_axis_input1_tvalid  in  1  input 1 valid.
- s_axis_input1_tready  out  1  input 1 ready.
- m_axis_output0_tdata  out  ELEM_WIDTH*SDIM  registered output beat.
- m_axis_output0_tvalid  out  1  output valid.
- m_axis_output0_tready  in  1  downstream ready.
- m_axis_output0_tlast  out  1  last beat of block.
- m_axis_output0_tuser  out  1  source id of current beat.
- busy  out  1  high in XFER state.

Behaviour:
- Reset values (ap_rst=1 at an edge):
  - all outputs 0; state=IDLE; beat_cnt=0; output register cleared; last_grant=1, so input 0 wins the first tie.
  - Reset mid-block discards in-flight data and any partial block.
- Output register: single stage. Load enable ld_ok = !m_tvalid || m_tready. m_tvalid clears when m_tready=1 and no new beat loads.
- State IDLE:
  - both s_tready=0, busy=0.
  - req[i] = s_tvalid[i] & cfg_mask[i].
  - No req: stay in IDLE.
  - One req: grant it.
  - Both req: grant !last_grant (round robin).
  - On grant: grant<=winner, beat_cnt<=0, state<=XFER. The arbitration cycle is always one bubble cycle per block.
- State XFER:
  - busy=1; s_tready[grant]=ld_ok; the other input's tready=0.
  - Beat accepted on s_tvalid[grant] & ld_ok. The output register takes tdata, tuser=grant, tlast=(beat_cnt==BPB-1); beat_cnt increments.
  - On the accepted beat with beat_cnt==BPB-1: last_grant<=grant, beat_cnt<=0, state<=IDLE.
  - Grant is held across input tvalid gaps and output backpressure. No switching mid-block, even if the granted source stalls indefinitely.
- cfg_mask changes during XFER have no effect until IDLE.
- BPB==1: every beat has tlast=1; each block is followed by one arbitration cycle.
- Latency: request seen in IDLE at cycle t; first s_tready at t+1; beat visible on m_tvalid at t+2 with no backpressure.
- Throughput: BPB beats per BPB+1 cycles per block.
- Data is never dropped or duplicated. AXI-S stability holds: m_tdata, m_tlast and m_tuser are stable while m_tvalid=1 and m_tready=0.

Optional Feature:
- Macro: BLOCK_COUNTER_EN.
- Defined:
  - Adds outputs blk_count0 and blk_count1 [CNT_WIDTH-1:0].
  - Each increments on the accepted input beat with tlast for that source. Both clear to 0 on ap_rst. Both wrap modulo 2^CNT_WIDTH.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single source, m_tready=1, defaults (BPB=4): input0 streams 8 beats 0x01..0x08 → output shows 0x01..0x04 with tlast on 0x04, then one bubble, then 0x05..0x08 with tlast on 0x08; tuser=0 throughout.
- Both inputs valid continuously, cfg_mask=2'b11: output blocks alternate 0,1,0,1 by tuser, starting with input 0 after reset; each block is exactly 4 beats.
- Granted input 1 drops tvalid for 5 cycles after beat 2 while input 0 is valid: no input 0 beat appears until input 1 beat 4 (tlast) has been accepted.
- m_tready=0 for 3 cycles with m_tvalid=1: tdata, tlast and tuser are held. s_tready[grant]=0 while m_tvalid=1 and m_tready=0. No beat is lost, verified by sequence compare.
- cfg_mask=2'b01 with both inputs valid, then set to 2'b10 mid-block: the current input 0 block completes; the next grant goes to input 1.
- Assert ap_rst mid-block after beat 2 → next cycle all outputs 0. The first post-reset grant goes to input 0 with beat_cnt=0. With BLOCK_COUNTER_EN, after 3 blocks from each input, blk_count0=3 and blk_count1=3.
